// File: rtl/vtree_way_feeder.sv
// Round-robin record source feeding W pre-sorted key streams into vMERGE_SORTER_TREE.
// Optional tree output order checker enabled by defining VTREE_FEEDER_CHECK_EN.
module vtree_way_feeder #(
    parameter int W_LOG    = 6,
    parameter int P_LOG    = 3,
    parameter int DATW     = 64,
    parameter int KEYW     = 32,
    parameter int NBLK_LOG = 4,
    parameter int GAP      = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              i_start,
    input  logic [(1<<W_LOG)-1:0]             i_req,
    input  logic                              i_rdy,
    output logic [DATW*(1<<P_LOG)-1:0]        o_din,
    output logic                              o_dinen,
    output logic [W_LOG-1:0]                  o_idx,
    output logic                              o_busy,
    output logic                              o_done,
    input  logic [DATW-1:0]                   i_dot,
    input  logic                              i_doten,
    output logic                              o_err,
    output logic [15:0]                       o_err_cnt,
    output logic                              o_chk_done
);
    localparam int W  = 1 << W_LOG;
    localparam int P  = 1 << P_LOG;
    localparam int CW = NBLK_LOG + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_blk_cnt [W];
    logic [3:0]             r_lock    [W];
    logic [W-1:0]           r_term;
    logic [W_LOG-1:0]       r_ptr;
    logic                   r_dinen;
    logic [W_LOG-1:0]       r_idx;
    logic [DATW*P-1:0]      r_din;

    logic [W-1:0]           w_elig;
    logic                   w_gnt_vld;
    logic [W_LOG-1:0]       w_gnt_idx;
    logic [CW-1:0]          w_sel_cnt;
    logic [DATW*P-1:0]      w_blk;
    logic                   w_restart;

    assign w_restart = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;

    always_comb begin
        w_elig = '0;
        for (int unsigned w = 0; w < W; w++)
            w_elig[w] = (r_state == S_RUN) && i_req[w] && (r_lock[w] == 4'd0) && !r_term[w];
    end

    // First eligible way at or after the pointer; the W_LOG-bit add wraps modulo W.
    always_comb begin
        logic [W_LOG-1:0] v_cand;
        logic             v_found;
        v_found   = 1'b0;
        v_cand    = '0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < W; k++) begin
            v_cand = r_ptr + W_LOG'(k);
            if (!v_found && w_elig[v_cand]) begin
                v_found   = 1'b1;
                w_gnt_idx = v_cand;
            end
        end
        w_gnt_vld = v_found && i_rdy;
    end

    assign w_sel_cnt = r_blk_cnt[w_gnt_idx];

    // Key = (b*P + j)*W + w + 1, i.e. the bit concatenation {b, j, w} plus one.
    always_comb begin
        w_blk = '0;
        for (int unsigned j = 0; j < P; j++)
            w_blk[DATW*j +: DATW] = w_sel_cnt[NBLK_LOG] ? {DATW{1'b1}} :
                {{(DATW-KEYW){1'b1}},
                 KEYW'({w_sel_cnt[NBLK_LOG-1:0], P_LOG'(j), w_gnt_idx}) + KEYW'(1)};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_state_nxt = S_RUN;
            S_RUN:          if (&r_term) w_state_nxt = S_DRAIN;
            S_DRAIN:        w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_term  <= '0;
            r_ptr   <= '0;
            r_dinen <= 1'b0;
            r_idx   <= '0;
            r_din   <= '0;
            for (int unsigned w = 0; w < W; w++) begin
                r_blk_cnt[w] <= '0;
                r_lock[w]    <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_dinen <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_idx <= w_gnt_idx;
                r_din <= w_blk;
                r_ptr <= w_gnt_idx + W_LOG'(1);
            end
            for (int unsigned w = 0; w < W; w++) begin
                if (w_restart) begin
                    r_blk_cnt[w] <= '0;
                    r_lock[w]    <= '0;
                    r_term[w]    <= 1'b0;
                end else if (w_gnt_vld && (w_gnt_idx == W_LOG'(w))) begin
                    r_lock[w] <= 4'(GAP);
                    if (w_sel_cnt[NBLK_LOG]) r_term[w] <= 1'b1;
                    else                     r_blk_cnt[w] <= r_blk_cnt[w] + CW'(1);
                end else if (r_lock[w] != 4'd0) begin
                    r_lock[w] <= r_lock[w] - 4'd1;
                end
            end
        end
    end

    assign o_dinen = r_dinen;
    assign o_idx   = r_idx;
    assign o_din   = r_din;
    assign o_busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done  = (r_state == S_DONE);

`ifdef VTREE_FEEDER_CHECK_EN
    localparam int TOTW = W_LOG + P_LOG + NBLK_LOG + 1;
    localparam logic [TOTW-1:0] TOT = TOTW'(1) << (TOTW - 1);

    logic [TOTW-1:0] r_chk_cnt;
    logic            r_err;
    logic [15:0]     r_err_cnt;
    logic            w_full;
    logic            w_bad;
    logic [DATW-1:0] w_exp_rec;

    assign w_full    = (r_chk_cnt == TOT);
    assign w_exp_rec = {{(DATW-KEYW){1'b1}}, KEYW'(r_chk_cnt) + KEYW'(1)};
    assign w_bad     = w_full ? (i_dot != {DATW{1'b1}}) : (i_dot != w_exp_rec);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_chk_cnt <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_restart) begin
            r_chk_cnt <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (i_doten) begin
            if (!w_full) r_chk_cnt <= r_chk_cnt + TOTW'(1);
            if (w_bad) begin
                r_err <= 1'b1;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_err      = r_err;
    assign o_err_cnt  = r_err_cnt;
    assign o_chk_done = w_full;
`else
    logic w_unused;
    assign w_unused   = ^{i_dot, i_doten};
    assign o_err      = 1'b0;
    assign o_err_cnt  = '0;
    assign o_chk_done = 1'b0;
`endif
endmodule

// File: tb/tb_vtree_way_feeder.sv
// Bench for vtree_way_feeder: cycle model of the grant/key rules plus directed literal checks.
module tb_vtree_way_feeder;
    localparam int W_LOG = 6, P_LOG = 3, DATW = 64, KEYW = 32, NBLK_LOG = 4, GAP = 2;
    localparam int W = 64, P = 8, NB = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 rdy = 1'b0;
    logic [W-1:0]         req = '0;
    logic [DATW-1:0]      dot = '0;
    logic                 doten = 1'b0;
    logic [DATW*P-1:0]    o_din;
    logic                 o_dinen;
    logic [W_LOG-1:0]     o_idx;
    logic                 o_busy, o_done, o_err, o_chk_done;
    logic [15:0]          o_err_cnt;

    vtree_way_feeder #(.W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW),
                       .NBLK_LOG(NBLK_LOG), .GAP(GAP)) dut (
        .CLK(clk), .RST(rst), .i_start(start), .i_req(req), .i_rdy(rdy),
        .o_din(o_din), .o_dinen(o_dinen), .o_idx(o_idx), .o_busy(o_busy), .o_done(o_done),
        .i_dot(dot), .i_doten(doten), .o_err(o_err), .o_err_cnt(o_err_cnt),
        .o_chk_done(o_chk_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [511:0] model_block(input int w, input int b);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < P; j++)
            if (b == NB) r[j*64 +: 64] = '1;
            else         r[j*64 +: 64] = {32'hFFFF_FFFF, 32'(w + 1 + (b*P + j)*W)};
        return r;
    endfunction

    // Model: phase 0=idle 1=run 2=drain 3=done; eligibility by time since last grant.
    int           m_phase = 0;
    int           m_blk [W];
    bit           m_term [W];
    longint       m_last [W];
    int           m_ptr = 0;
    longint       m_cyc = 0;
    logic         m_dinen = 1'b0;
    int           m_idx = 0;
    logic [511:0] m_din = '0;
    bit           m_allt, m_g;
    int           m_gw, m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_dinen = 1'b0; m_idx = 0; m_din = '0;
            for (int w = 0; w < W; w++) begin m_blk[w] = 0; m_term[w] = 0; m_last[w] = m_cyc - 100; end
        end else begin
            m_allt = 1;
            for (int w = 0; w < W; w++) m_allt &= m_term[w];
            m_g = 0; m_gw = 0;
            if (m_phase == 1 && rdy)
                for (int k = 0; k < W; k++) begin
                    m_w = (m_ptr + k) % W;
                    if (!m_g && req[m_w] && !m_term[m_w] && (m_cyc - m_last[m_w] > GAP)) begin
                        m_g = 1; m_gw = m_w;
                    end
                end
            m_dinen = m_g;
            if (m_g) begin
                m_idx = m_gw;
                m_din = model_block(m_gw, m_blk[m_gw]);
                if (m_blk[m_gw] == NB) m_term[m_gw] = 1; else m_blk[m_gw]++;
                m_last[m_gw] = m_cyc;
                m_ptr = (m_gw + 1) % W;
            end
            case (m_phase)
                0, 3: if (start) begin
                    m_phase = 1;
                    for (int w = 0; w < W; w++) begin m_blk[w] = 0; m_term[w] = 0; m_last[w] = m_cyc - 100; end
                end
                1: if (m_allt) m_phase = 2;
                2: m_phase = 3;
                default: m_phase = 0;
            endcase
            m_cyc++;
        end
    end

    int last_seen_idx = 0;
    always @(negedge clk) begin
        if (!rst) begin
            cmp("dinen", o_dinen, m_dinen);
            if (m_dinen) cmp("idx", o_idx, m_idx);
            cmp("din", o_din, m_din);
            cmp("busy", o_busy, (m_phase == 1) || (m_phase == 2));
            cmp("done", o_done, m_phase == 3);
            if (o_dinen) last_seen_idx = o_idx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_emit(input int budget, output logic [W_LOG-1:0] idx, output logic [511:0] din);
        bit ok;
        ok = 0; idx = '0; din = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (o_dinen) begin ok = 1; idx = o_idx; din = o_din; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL emit_timeout: got no o_dinen expected one within %0d cycles", budget);
        end
    endtask

    logic [W_LOG-1:0] e_idx;
    logic [511:0]     e_din;
    logic [W_LOG-1:0] l_idx;
    int               cnt;
    bit               seen;

    initial begin
        tick(3);
        cmp("rst_din", o_din, '0);
        cmp("rst_ctl", {o_dinen, o_idx, o_busy, o_done, o_err, o_err_cnt, o_chk_done}, '0);
        rst = 1'b0; req = '1; rdy = 1'b1; start = 1'b1;
        tick(1); start = 1'b0;

        wait_emit(10, e_idx, e_din);
        cmp("first_idx", e_idx, 0);
        cmp("first_slot0", e_din[63:0], 64'hFFFF_FFFF_0000_0001);
        cmp("first_slot7", e_din[7*64 +: 64], 64'hFFFF_FFFF_0000_01C1);
        wait_emit(3, e_idx, e_din);
        cmp("second_idx", e_idx, 1);
        wait_emit(3, e_idx, e_din);
        cmp("third_idx", e_idx, 2);
        tick(20);

        rdy = 1'b0; tick(1);
        cnt = 0;
        repeat (9) begin @(negedge clk); if (o_dinen) cnt++; end
        cmp("stall_quiet", cnt, 0);
        l_idx = W_LOG'(last_seen_idx);
        rdy = 1'b1;
        wait_emit(5, e_idx, e_din);
        cmp("resume_idx", e_idx, l_idx + W_LOG'(1));

        rst = 1'b1; tick(2); rst = 1'b0;
        req = '0; req[5] = 1'b1; req[40] = 1'b1; start = 1'b1;
        tick(1); start = 1'b0;
        wait_emit(10, e_idx, e_din);
        cmp("pair_a_idx", e_idx, 5);
        cmp("pair_a_key", e_din[63:0], 64'hFFFF_FFFF_0000_0006);
        wait_emit(5, e_idx, e_din);
        cmp("pair_b_idx", e_idx, 40);
        wait_emit(5, e_idx, e_din);
        cmp("pair_c_idx", e_idx, 5);
        cmp("pair_c_key", e_din[63:0], 64'hFFFF_FFFF_0000_0206);
        wait_emit(5, e_idx, e_din);
        cmp("pair_d_idx", e_idx, 40);

        req = '0; tick(4);
        req[3] = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            wait_emit(6, e_idx, e_din);
            cmp("way3_idx", e_idx, 3);
            if (n == 16) cmp("way3_last_key", e_din[7*64 +: 64], 64'hFFFF_FFFF_0000_1FC4);
            if (n == 17) cmp("way3_term", e_din, {512{1'b1}});
        end
        cnt = 0;
        repeat (30) begin @(negedge clk); if (o_dinen) cnt++; end
        cmp("way3_silent", cnt, 0);

        req = '1;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1;
        end
        cmp("done_reached", seen, 1);
        cmp("busy_low_at_done", o_busy, 0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_emit(10, e_idx, e_din);
        cmp("restart_key", e_din[63:0], {32'hFFFF_FFFF, 26'd0, e_idx} + 64'd1);

        tick(5);
        #2 rst = 1'b1;
        #1;
        cmp("abort_din", o_din, '0);
        cmp("abort_ctl", {o_dinen, o_idx, o_busy, o_done, o_err, o_err_cnt, o_chk_done}, '0);
        tick(2);
        rst = 1'b0;

        for (int k = 1; k <= 8192; k++) begin
            if (k == 8192) cmp("chk_not_yet", o_chk_done, 0);
            dot = {32'hFFFF_FFFF, 32'((k == 100) ? 101 : (k == 101) ? 100 : k)};
            doten = 1'b1;
            tick(1);
        end
        doten = 1'b0; tick(1);
`ifdef VTREE_FEEDER_CHECK_EN
        cmp("chk_err", o_err, 1);
        cmp("chk_err_cnt", o_err_cnt, 2);
        cmp("chk_done", o_chk_done, 1);
`else
        cmp("chk_err", o_err, 0);
        cmp("chk_err_cnt", o_err_cnt, 0);
        cmp("chk_done", o_chk_done, 0);
`endif
        dot = '1; doten = 1'b1; tick(1); doten = 1'b0; tick(1);
`ifdef VTREE_FEEDER_CHECK_EN
        cmp("chk_ones_ok", o_err_cnt, 2);
`else
        cmp("chk_ones_ok", o_err_cnt, 0);
`endif
        dot = 64'h5; doten = 1'b1; tick(1); doten = 1'b0; tick(1);
`ifdef VTREE_FEEDER_CHECK_EN
        cmp("chk_junk", o_err_cnt, 3);
`else
        cmp("chk_junk", o_err_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
